datapath: RTL and testbench
===========================

# datapath

Mini-SRC 32-bit single-bus processor datapath: register file, special registers (PC, IR, HI, LO, Y, Z, MAR, MDR), ALU, select-and-encode logic, CON flip-flop, I/O port registers and a 512×32 word RAM. It has no control unit. An external control-step sequencer drives every load, drive, ALU-op and memory strobe cycle by cycle. Benches use it to run instructions step by step (fetch T0–T2, then execute T3…).

## Interface
- No parameters. RAM instance is named `ram_instance` with word array `memory[0:511]`, so benches can preload it hierarchically.
- Clock  in  1  single clock; all state updates on rising edge.
- Clear  in  1  asynchronous, active-low reset.
- PCin, IRin, HIin, LOin, MARin, MDRin, Yin  in  1 each  load named register from bus.
- ZHighin / ZLowin  in  1 each  load Z[63:32] / Z[31:0] from ALU result.
- OutPort  in  1  load out-port register from bus.
- PCout, HIout, LOout, ZHighout, ZLowout, MDRout  in  1 each  drive named register onto bus.
- InPort  in  1  drive in-port register onto bus.
- Cout  in  1  drive sign-extended constant C onto bus.
- Gra, Grb, Grc  in  1 each  select register field IR[26:23] / IR[22:19] / IR[18:15].
- GLR  in  1  select link register R15, overriding Gra/Grb/Grc.
- Rin, Rout, BAout  in  1 each  load / drive / base-address-drive the selected register.
- Read, Write  in  1 each  memory read path select / memory write.
- IncPC  in  1  PC ← PC+1.
- CON_In  in  1  load CON flip-flop.
- OP  in  5  ALU operation.
- CON_Out  out  1  CON flip-flop value.

## Operation
- Bus source priority: R0–R15, HI, LO, ZHigh, ZLow, PC, MDR, InPort, C. If no source is driven, bus = 0. Control guarantees at most one source.
- Select-and-encode register index:
  - GLR → 15.
  - Otherwise the OR of (Gra&IR[26:23]), (Grb&IR[22:19]), (Grc&IR[18:15]).
  - Rin loads that register. Rout drives it.
  - BAout also drives it, but drives 0 when the index is R0.
- C = IR[18:0] sign-extended to 32 bits.
- MDR input mux: Read=1 → memory[MAR[8:0]] (combinational read); else bus.
- Write=1 → memory[MAR[8:0]] ← MDR at the clock edge.
- ALU operands: A = Y, B = bus. Output is a 64-bit result; ops other than mul/div put 0 in the high word.
- OP codes:
  - 0,1,2,3,12: add.
  - 4: sub (A−B).
  - 5,13: and. 6,14: or.
  - 7: ror A by B[4:0]. 8: rol A by B[4:0].
  - 9: shr (logical). 10: shra (arithmetic). 11: shl.
  - 15: div, signed. Low = quotient, high = remainder. Divide by 0 → result 0.
  - 16: mul, signed 64-bit product.
  - 17: neg B. 18: not B.
  - Any other code: low = B.
- CON on CON_In captures the condition selected by IR[20:19], evaluated on the bus:
  - 00: bus==0. 01: bus!=0. 10: bus[31]==0. 11: bus[31]==1.
- IncPC and PCin asserted together: PCin wins.
- In-port register: 32 bits, cleared by reset, preloadable hierarchically only.

## Timing
- Clear low → immediately all registers (R0–R15, PC, IR, HI, LO, Y, Z, MAR, MDR, in/out ports, CON) = 0. RAM is not cleared.
- A reset mid-sequence aborts the sequence. Releasing Clear has no effect until the next edge.
- Every load is captured at the rising edge while its strobe is high. A strobe held across two edges loads twice; that is legal.
- Memory fetch: PCout+MARin+Read+MDRin held two edges. Edge 1: MAR ← PC. Edge 2: MDR ← mem[MAR].
- ALU is combinational. Z captures the result in the same cycle the B source is on the bus.

## Test plan
- **Reset:** pulse Clear low mid-clock → all registers 0, CON_Out 0 without a clock edge.
- **jal R2:**
  - Setup: memory[0]=A9000000; fetch T0 (PC→MAR, Read/MDRin), T1 IncPC, T2 MDRout/IRin.
  - Expect after fetch: IR=A9000000, PC=1.
  - T3 GLR/PCout/Rin → R15=1.
  - T4 Gra/Rout/PCin → PC=R2=0.
- **ld R1,0x55:** memory[0x55]=0xDEADBEEF; C=0x55 via Cout→MAR, Read/MDRin, MDRout→R1 → R1=DEADBEEF.
- **mul / div:**
  - mul: Y=−3, bus=7 → HI=FFFFFFFF, LO=FFFFFFEB.
  - div: Y=17, bus=5 → LO=3, HI=2.
  - div: Y=17, bus=0 → HI=LO=0.
- **ALU spot checks:**
  - shra 0x80000000 by 4 → F8000000.
  - ror 0x00000001 by 1 → 80000000.
  - sub 5−7 → FFFFFFFE.
- **brzr CON:** IR[20:19]=00.
  - Bus=0 with CON_In → CON_Out=1.
  - Bus=1 → CON_Out=0.
  - IR[20:19]=11 with bus=80000000 → 1.

Source files
------------

// File: rtl/datapath.sv
// Mini-SRC single-bus datapath: register file, special registers, ALU, select/encode,
// CON flip-flop, I/O port registers and a 512x32 RAM, all steered by external strobes.

module datapath_ram (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [8:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_c_o
);
    // Not reset: contents survive Clear so code/data can be preloaded once.
    logic [31:0] memory [0:511];

    always_ff @(posedge clk_i) begin
        if (we_i) memory[addr_i] <= wdata_i;
    end

    assign rdata_c_o = memory[addr_i];
endmodule

module datapath (
    input  logic       Clock,
    input  logic       Clear,
    input  logic       PCin,
    input  logic       IRin,
    input  logic       HIin,
    input  logic       LOin,
    input  logic       MARin,
    input  logic       MDRin,
    input  logic       Yin,
    input  logic       ZHighin,
    input  logic       ZLowin,
    input  logic       OutPort,
    input  logic       PCout,
    input  logic       HIout,
    input  logic       LOout,
    input  logic       ZHighout,
    input  logic       ZLowout,
    input  logic       MDRout,
    input  logic       InPort,
    input  logic       Cout,
    input  logic       Gra,
    input  logic       Grb,
    input  logic       Grc,
    input  logic       GLR,
    input  logic       Rin,
    input  logic       Rout,
    input  logic       BAout,
    input  logic       Read,
    input  logic       Write,
    input  logic       IncPC,
    input  logic       CON_In,
    input  logic [4:0] OP,
    output logic       CON_Out
);
    localparam int unsigned DW   = 32;
    localparam int unsigned NREG = 16;
    localparam int unsigned AW   = 9;

    logic [DW-1:0]   r_q [NREG];
    logic [DW-1:0]   r_d [NREG];
    logic [DW-1:0]   pc_q, pc_d, ir_q, ir_d, hi_q, hi_d, lo_q, lo_d, y_q, y_d;
    logic [DW-1:0]   mar_q, mar_d, mdr_q, mdr_d, inport_q, inport_d, outport_q, outport_d;
    logic [2*DW-1:0] z_q, z_d;
    logic            con_q, con_d;

    logic [3:0]      sel_idx_c;
    logic [DW-1:0]   c_sext_c, bus_c, mem_rdata_c;
    logic [2*DW-1:0] alu_c, rotr_c, rotl_c, prod_c;
    logic [DW-1:0]   divisor_c, quot_c, rem_c;
    logic [4:0]      sh_c;
    logic            cond_c;
    logic            unused_c;

    datapath_ram ram_instance (
        .clk_i     (Clock),
        .we_i      (Write),
        .addr_i    (mar_q[AW-1:0]),
        .wdata_i   (mdr_q),
        .rdata_c_o (mem_rdata_c)
    );

    // Select-and-encode: GLR forces the link register, else OR of gated IR fields.
    always_comb begin
        sel_idx_c = 4'd15;
        if (!GLR) begin
            sel_idx_c = ({4{Gra}} & ir_q[26:23]) | ({4{Grb}} & ir_q[22:19])
                      | ({4{Grc}} & ir_q[18:15]);
        end
    end

    assign c_sext_c = {{(DW-19){ir_q[18]}}, ir_q[18:0]};

    // Bus source mux in fixed priority order; idle bus reads as zero.
    always_comb begin
        bus_c = '0;
        if (Rout)          bus_c = r_q[sel_idx_c];
        else if (BAout)    bus_c = (sel_idx_c == 4'd0) ? '0 : r_q[sel_idx_c];
        else if (HIout)    bus_c = hi_q;
        else if (LOout)    bus_c = lo_q;
        else if (ZHighout) bus_c = z_q[2*DW-1:DW];
        else if (ZLowout)  bus_c = z_q[DW-1:0];
        else if (PCout)    bus_c = pc_q;
        else if (MDRout)   bus_c = mdr_q;
        else if (InPort)   bus_c = inport_q;
        else if (Cout)     bus_c = c_sext_c;
    end

    // ALU: A = Y, B = bus; only mul/div produce a non-zero high word.
    always_comb begin
        sh_c      = bus_c[4:0];
        rotr_c    = {y_q, y_q} >> sh_c;
        rotl_c    = {y_q, y_q} << sh_c;
        prod_c    = 64'($signed(y_q)) * 64'($signed(bus_c));
        divisor_c = (bus_c == '0) ? 32'd1 : bus_c;
        quot_c    = 32'($signed(y_q) / $signed(divisor_c));
        rem_c     = 32'($signed(y_q) % $signed(divisor_c));
        alu_c     = '0;
        case (OP)
            5'd0, 5'd1, 5'd2, 5'd3, 5'd12: alu_c[DW-1:0] = y_q + bus_c;
            5'd4:           alu_c[DW-1:0] = y_q - bus_c;
            5'd5, 5'd13:    alu_c[DW-1:0] = y_q & bus_c;
            5'd6, 5'd14:    alu_c[DW-1:0] = y_q | bus_c;
            5'd7:           alu_c[DW-1:0] = rotr_c[DW-1:0];
            5'd8:           alu_c[DW-1:0] = rotl_c[2*DW-1:DW];
            5'd9:           alu_c[DW-1:0] = y_q >> sh_c;
            5'd10:          alu_c[DW-1:0] = 32'($signed(y_q) >>> sh_c);
            5'd11:          alu_c[DW-1:0] = y_q << sh_c;
            5'd15:          alu_c = (bus_c == '0) ? '0 : {rem_c, quot_c};
            5'd16:          alu_c = prod_c;
            5'd17:          alu_c[DW-1:0] = 32'd0 - bus_c;
            5'd18:          alu_c[DW-1:0] = ~bus_c;
            default:        alu_c[DW-1:0] = bus_c;
        endcase
    end

    // Branch condition chosen by IR[20:19], evaluated on the bus.
    always_comb begin
        cond_c = 1'b0;
        case (ir_q[20:19])
            2'b00:   cond_c = (bus_c == '0);
            2'b01:   cond_c = (bus_c != '0);
            2'b10:   cond_c = ~bus_c[DW-1];
            default: cond_c = bus_c[DW-1];
        endcase
    end

    // Next-state for every register; PCin outranks IncPC.
    always_comb begin
        r_d = r_q;
        if (Rin) r_d[sel_idx_c] = bus_c;
        pc_d = pc_q;
        if (PCin)       pc_d = bus_c;
        else if (IncPC) pc_d = pc_q + 32'd1;
        ir_d      = IRin    ? bus_c : ir_q;
        hi_d      = HIin    ? bus_c : hi_q;
        lo_d      = LOin    ? bus_c : lo_q;
        y_d       = Yin     ? bus_c : y_q;
        mar_d     = MARin   ? bus_c : mar_q;
        mdr_d     = MDRin   ? (Read ? mem_rdata_c : bus_c) : mdr_q;
        outport_d = OutPort ? bus_c : outport_q;
        inport_d  = inport_q;
        z_d       = z_q;
        if (ZHighin) z_d[2*DW-1:DW] = alu_c[2*DW-1:DW];
        if (ZLowin)  z_d[DW-1:0]    = alu_c[DW-1:0];
        con_d     = CON_In ? cond_c : con_q;
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            r_q       <= '{default: '0};
            pc_q      <= '0;
            ir_q      <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            y_q       <= '0;
            z_q       <= '0;
            mar_q     <= '0;
            mdr_q     <= '0;
            inport_q  <= '0;
            outport_q <= '0;
            con_q     <= 1'b0;
        end else begin
            r_q       <= r_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            y_q       <= y_d;
            z_q       <= z_d;
            mar_q     <= mar_d;
            mdr_q     <= mdr_d;
            inport_q  <= inport_d;
            outport_q <= outport_d;
            con_q     <= con_d;
        end
    end

    assign CON_Out = con_q;

    // Out-port and upper MAR/IR bits have no consumer inside this block.
    assign unused_c = ^{outport_q, mar_q[DW-1:AW], ir_q[31:27]};
endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for the Mini-SRC datapath: drives control steps directly and
// compares register state against spec constants and a behavioural ALU/CON model.

module tb_datapath;
    logic       Clock, Clear;
    logic       PCin, IRin, HIin, LOin, MARin, MDRin, Yin, ZHighin, ZLowin, OutPort;
    logic       PCout, HIout, LOout, ZHighout, ZLowout, MDRout, InPort, Cout;
    logic       Gra, Grb, Grc, GLR, Rin, Rout, BAout, Read, Write, IncPC, CON_In;
    logic [4:0] OP;
    logic       CON_Out;

    int          checks;
    int          errors;
    logic [31:0] m_pc;

    localparam logic [31:0] SEL_IR = (32'd1 << 19) | (32'd2 << 15);

    datapath dut (
        .Clock(Clock), .Clear(Clear), .PCin(PCin), .IRin(IRin), .HIin(HIin), .LOin(LOin),
        .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .ZHighin(ZHighin), .ZLowin(ZLowin),
        .OutPort(OutPort), .PCout(PCout), .HIout(HIout), .LOout(LOout),
        .ZHighout(ZHighout), .ZLowout(ZLowout), .MDRout(MDRout), .InPort(InPort),
        .Cout(Cout), .Gra(Gra), .Grb(Grb), .Grc(Grc), .GLR(GLR), .Rin(Rin), .Rout(Rout),
        .BAout(BAout), .Read(Read), .Write(Write), .IncPC(IncPC), .CON_In(CON_In),
        .OP(OP), .CON_Out(CON_Out)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference ALU written from the operation table with plain arithmetic and bit loops.
    function automatic logic [63:0] alu_ref(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int          sa, sb, s;
        longint      p;
        logic [31:0] hi, lo;
        sa = a; sb = b; s = int'(b[4:0]); hi = '0; lo = '0;
        case (op)
            5'd0, 5'd1, 5'd2, 5'd3, 5'd12: lo = a + b;
            5'd4:        lo = a - b;
            5'd5, 5'd13: lo = a & b;
            5'd6, 5'd14: lo = a | b;
            5'd7:  for (int i = 0; i < 32; i++) lo[5'(i)] = a[5'(i + s)];
            5'd8:  for (int i = 0; i < 32; i++) lo[5'(i + s)] = a[5'(i)];
            5'd9:  lo = a >> s;
            5'd10: for (int i = 0; i < 32; i++) lo[5'(i)] = (i + s < 32) ? a[5'(i + s)] : a[31];
            5'd11: lo = a << s;
            5'd15: if (b != 0) begin lo = 32'(sa / sb); hi = 32'(sa % sb); end
            5'd16: begin p = longint'(sa) * longint'(sb); {hi, lo} = p; end
            5'd17: lo = 32'd0 - b;
            5'd18: lo = ~b;
            default: lo = b;
        endcase
        return {hi, lo};
    endfunction

    function automatic logic con_ref(input logic [1:0] cond, input logic [31:0] v);
        case (cond)
            2'd0:    return v == 0;
            2'd1:    return v != 0;
            2'd2:    return v[31] == 1'b0;
            default: return v[31] == 1'b1;
        endcase
    endfunction

    task automatic clear_ctrl();
        PCin = 0; IRin = 0; HIin = 0; LOin = 0; MARin = 0; MDRin = 0; Yin = 0;
        ZHighin = 0; ZLowin = 0; OutPort = 0; PCout = 0; HIout = 0; LOout = 0;
        ZHighout = 0; ZLowout = 0; MDRout = 0; InPort = 0; Cout = 0; Gra = 0; Grb = 0;
        Grc = 0; GLR = 0; Rin = 0; Rout = 0; BAout = 0; Read = 0; Write = 0; IncPC = 0;
        CON_In = 0; OP = '0;
    endtask

    // One control step: strobes set before the call are captured at the next rising edge.
    task automatic step();
        @(posedge Clock);
        #1;
        clear_ctrl();
    endtask

    task automatic do_reset();
        clear_ctrl();
        Clear = 1'b0;
        #3;
        Clear = 1'b1;
        m_pc = '0;
    endtask

    task automatic fetch(input logic [31:0] word);
        dut.ram_instance.memory[m_pc[8:0]] = word;
        PCout = 1; MARin = 1; Read = 1; MDRin = 1; step();
        IncPC = 1; Read = 1; MDRin = 1; step();
        MDRout = 1; IRin = 1; step();
        m_pc = m_pc + 1;
    endtask

    task automatic load_reg(input logic [3:0] r, input logic [8:0] addr, input logic [31:0] v);
        dut.ram_instance.memory[addr] = v;
        fetch((32'(r) << 23) | 32'(addr));
        Cout = 1; MARin = 1; step();
        Read = 1; MDRin = 1; step();
        Gra = 1; MDRout = 1; Rin = 1; step();
    endtask

    // R1 = a, R2 = b, Y <- R1, Z <- Y op R2, then Z moved into HI/LO.
    task automatic alu_run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] hi, output logic [31:0] lo);
        load_reg(4'd1, 9'h100, a);
        load_reg(4'd2, 9'h101, b);
        fetch(SEL_IR);
        Grb = 1; Rout = 1; Yin = 1; step();
        Grc = 1; Rout = 1; OP = op; ZHighin = 1; ZLowin = 1; step();
        ZLowout = 1; LOin = 1; step();
        ZHighout = 1; HIin = 1; step();
        hi = dut.hi_q;
        lo = dut.lo_q;
    endtask

    task automatic con_run(input logic [1:0] cond, input logic [31:0] v, output logic got);
        load_reg(4'd3, 9'h102, v);
        fetch((32'd3 << 23) | (32'(cond) << 19));
        Gra = 1; Rout = 1; CON_In = 1; step();
        got = CON_Out;
    endtask

    function automatic logic [31:0] or_all_regs();
        logic [31:0] acc;
        acc = dut.pc_q | dut.ir_q | dut.hi_q | dut.lo_q | dut.y_q | dut.z_q[63:32]
            | dut.z_q[31:0] | dut.mar_q | dut.mdr_q | dut.inport_q | dut.outport_q;
        for (int i = 0; i < 16; i++) acc = acc | dut.r_q[4'(i)];
        return acc;
    endfunction

    task automatic test_reset();
        logic        got;
        logic [31:0] acc;
        do_reset();
        checks++;
        acc = or_all_regs();
        if (acc !== 32'd0 || CON_Out !== 1'b0) begin
            errors++; $display("FAIL reset_power_on: regs_or=%h con=%b expected 0/0", acc, CON_Out);
        end
        load_reg(4'd5, 9'h130, 32'h1234_5678);
        OutPort = 1; Gra = 1; Rout = 1; step();
        con_run(2'd0, 32'd0, got);
        checks++;
        if (got !== 1'b1) begin
            errors++; $display("FAIL reset_precon: con=%b expected 1", got);
        end
        #3;
        Clear = 1'b0;
        #1;
        checks++;
        acc = or_all_regs();
        if (acc !== 32'd0 || CON_Out !== 1'b0) begin
            errors++; $display("FAIL reset_async: regs_or=%h con=%b expected 0/0", acc, CON_Out);
        end
        checks++;
        if (dut.ram_instance.memory[9'h130] !== 32'h1234_5678) begin
            errors++;
            $display("FAIL reset_ram_kept: got %h expected 12345678", dut.ram_instance.memory[9'h130]);
        end
        Clear = 1'b1;
        m_pc = '0;
        step();
    endtask

    task automatic test_jal();
        do_reset();
        fetch(32'hA900_0000);
        checks++;
        if (dut.ir_q !== 32'hA900_0000 || dut.pc_q !== 32'd1) begin
            errors++; $display("FAIL jal_fetch: ir=%h pc=%h expected A9000000/1", dut.ir_q, dut.pc_q);
        end
        GLR = 1; PCout = 1; Rin = 1; step();
        checks++;
        if (dut.r_q[15] !== 32'd1) begin
            errors++; $display("FAIL jal_link: r15=%h expected 1", dut.r_q[15]);
        end
        Gra = 1; Rout = 1; PCin = 1; step();
        m_pc = '0;
        checks++;
        if (dut.pc_q !== 32'd0) begin
            errors++; $display("FAIL jal_jump: pc=%h expected 0", dut.pc_q);
        end
    endtask

    task automatic test_ld();
        do_reset();
        load_reg(4'd1, 9'h055, 32'hDEAD_BEEF);
        checks++;
        if (dut.ir_q !== 32'h0080_0055 || dut.r_q[1] !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL ld_r1: ir=%h r1=%h expected 00800055/DEADBEEF", dut.ir_q, dut.r_q[1]);
        end
    endtask

    task automatic test_alu_spot();
        logic [4:0]  ops [6]  = '{5'd16, 5'd15, 5'd15, 5'd10, 5'd7, 5'd4};
        logic [31:0] as  [6]  = '{32'hFFFF_FFFD, 32'd17, 32'd17, 32'h8000_0000, 32'd1, 32'd5};
        logic [31:0] bs  [6]  = '{32'd7, 32'd5, 32'd0, 32'd4, 32'd1, 32'd7};
        logic [31:0] ehi [6]  = '{32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0};
        logic [31:0] elo [6]  = '{32'hFFFF_FFEB, 32'd3, 32'd0, 32'hF800_0000, 32'h8000_0000,
                                  32'hFFFF_FFFE};
        logic [31:0] hi, lo;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            alu_run(ops[i], as[i], bs[i], hi, lo);
            checks++;
            if (hi !== ehi[i] || lo !== elo[i]) begin
                errors++;
                $display("FAIL alu_spot[%0d] op=%0d: got %h_%h expected %h_%h",
                         i, ops[i], hi, lo, ehi[i], elo[i]);
            end
        end
    endtask

    task automatic test_alu_random();
        logic [4:0]  op;
        logic [31:0] a, b, hi, lo;
        logic [63:0] exp;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            op = 5'($urandom_range(0, 31));
            if (i < 19) op = 5'(i);
            a  = $urandom();
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom();
            alu_run(op, a, b, hi, lo);
            exp = alu_ref(op, a, b);
            checks++;
            if ({hi, lo} !== exp || dut.z_q !== exp) begin
                errors++;
                $display("FAIL alu_rand op=%0d a=%h b=%h: got %h_%h z=%h expected %h",
                         op, a, b, hi, lo, dut.z_q, exp);
            end
        end
    endtask

    task automatic test_con();
        logic [1:0]  conds [3] = '{2'd0, 2'd0, 2'd3};
        logic [31:0] vals  [3] = '{32'd0, 32'd1, 32'h8000_0000};
        logic        expv  [3] = '{1'b1, 1'b0, 1'b1};
        logic [1:0]  cond;
        logic [31:0] v;
        logic        got;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            con_run(conds[i], vals[i], got);
            checks++;
            if (got !== expv[i]) begin
                errors++; $display("FAIL con_spot[%0d]: got %b expected %b", i, got, expv[i]);
            end
        end
        for (int i = 0; i < 20; i++) begin
            cond = 2'($urandom_range(0, 3));
            v    = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
            con_run(cond, v, got);
            checks++;
            if (got !== con_ref(cond, v)) begin
                errors++;
                $display("FAIL con_rand cond=%0d v=%h: got %b expected %b", cond, v, got, con_ref(cond, v));
            end
        end
    endtask

    task automatic test_select_encode();
        logic [31:0] v0, v1, v15;
        v0  = $urandom() | 32'd1;
        v1  = $urandom() | 32'h100;
        v15 = $urandom() | 32'd2;
        do_reset();
        load_reg(4'd0, 9'h110, v0);
        load_reg(4'd15, 9'h112, v15);
        fetch(32'd0);
        BAout = 1; Gra = 1; Yin = 1; step();
        checks++;
        if (dut.y_q !== 32'd0) begin
            errors++; $display("FAIL baout_r0: y=%h expected 0", dut.y_q);
        end
        Rout = 1; Gra = 1; Yin = 1; step();
        checks++;
        if (dut.y_q !== v0) begin
            errors++; $display("FAIL rout_r0: y=%h expected %h", dut.y_q, v0);
        end
        load_reg(4'd1, 9'h111, v1);
        fetch((32'd1 << 23) | 32'h120);
        Cout = 1; MARin = 1; step();
        Gra = 1; Rout = 1; MDRin = 1; step();
        Write = 1; step();
        checks++;
        if (dut.ram_instance.memory[9'h120] !== v1) begin
            errors++; $display("FAIL mem_write: got %h expected %h", dut.ram_instance.memory[9'h120], v1);
        end
        GLR = 1; Gra = 1; Rout = 1; Yin = 1; step();
        checks++;
        if (dut.y_q !== v15) begin
            errors++; $display("FAIL glr_override: y=%h expected %h", dut.y_q, v15);
        end
        Gra = 1; Rout = 1; PCin = 1; IncPC = 1; step();
        checks++;
        if (dut.pc_q !== v1) begin
            errors++; $display("FAIL pcin_wins: pc=%h expected %h", dut.pc_q, v1);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_pc   = '0;
        Clear  = 1'b1;
        clear_ctrl();
        test_reset();
        test_jal();
        test_ld();
        test_alu_spot();
        test_alu_random();
        test_con();
        test_select_encode();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
